shift_add_mult_ctrl: RTL and testbench
======================================

# shift_add_mult_ctrl

Controller and accumulator stage for the sequential shift-add multiplier. It sits directly upstream of the right-shifting multiplier register and drives that register's load (`rst`) and `enable` inputs. On each step it consumes the register's LSB and conditionally adds the shifted multiplicand into a 2N-bit product accumulator. A start/busy/done handshake frames each multiplication; the final product is held until the next accepted start.

## Interface
- `N`, default 8: operand width in bits; legal for N ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiplication; sampled only in IDLE.
- `a`  in  N: multiplicand; captured on the edge that accepts `start`.
- `sr_lsb`  in  1: bit 0 of the downstream shift register's `Q`.
- `sr_load`  out  1: drives the shift register's `rst`/load pin, which loads multiplier B.
- `sr_enable`  out  1: drives the shift register's `enable`, one right shift per cycle.
- `p`  out  2N: product; valid from the DONE cycle until the next accepted start.
- `busy`  out  1: high in LOAD, RUN and DONE.
- `done`  out  1: one-cycle pulse in the DONE state.

## Operation
- State register with states IDLE, LOAD, RUN and DONE. Internal registers: `a_reg` (N bits), `acc` (2N bits) and step counter `cnt` (0..N-1).
- **IDLE:** `start`=1 → capture `a_reg`←`a`, set `acc`←0 and `cnt`←0, then go to LOAD. With `start`=0, stay in IDLE.
- **LOAD:** lasts exactly one cycle with `sr_load`=1. The shift register loads B asynchronously from its `IN` port. Next state is RUN.
- **RUN:** lasts exactly N cycles with `sr_enable`=1.
  - In RUN cycle k (k = 0..N-1), `sr_lsb` equals B[k].
  - At the end of each RUN cycle: if `sr_lsb`=1, then `acc`←`acc` + (`a_reg` << `cnt`); then `cnt`←`cnt`+1.
  - On the cycle where `cnt`=N-1, the last add is performed and the next state is DONE.
- **DONE:** one cycle. `done`=1 and `p`=`acc`. Next state is IDLE.
- Outputs `sr_load`, `sr_enable`, `busy` and `done` are decoded from the state register only; none depends combinationally on inputs.
- `p` is a register loaded from `acc` on the RUN→DONE edge. It holds its value through IDLE and through subsequent LOAD/RUN cycles until the next DONE.
- Width rule: the maximum sum (2^N−1)² fits in 2N bits. No overflow or carry-out is possible; the adder is exactly 2N bits wide.
- `start` while `busy`=1, including during DONE, is ignored and not queued.
- `a` changes after the accepting edge have no effect on the current operation.

## Timing
- Reset values: state=IDLE, `p`=0, `acc`=0, `cnt`=0, `a_reg`=0, `sr_load`=0, `sr_enable`=0, `busy`=0, `done`=0.
- Cycle numbering: `start` is accepted on edge E0. LOAD occupies cycle 1, RUN occupies cycles 2..N+1, and DONE occupies cycle N+2.
- Start-to-done latency is N+2 cycles (10 for N=8).
- The next `start` can be accepted on the first IDLE edge after DONE, giving a throughput of one product per N+3 cycles.
- Reset in any state, including mid-RUN, returns the block to IDLE at the next edge with all outputs at their reset values; the partial `acc` is discarded.
- `sr_load` deasserts on reset. Any external OR of the system reset onto the shift register's load pin is outside this block.
- `sr_enable` is never high in the same cycle as `sr_load`.

## Test plan
All scenarios instantiate the shift-right multiplier register downstream with B on its `IN`.
- N=8, a=0x0D, B=0x0B, pulse `start` → `sr_load` high for 1 cycle, `sr_enable` high for exactly 8 cycles, `done` pulse at cycle 10, `p`=0x008F held afterwards.
- N=8, a=0xFF, B=0xFF → `p`=0xFE01. Also a=0x00, B=0xAB → `p`=0x0000. Also a=0xAB, B=0x00 → `p`=0x0000 with 8 RUN cycles still executed.
- `start` held high continuously with a=0x03, B=0x05 → exactly one operation per N+3 cycles. `p`=0x000F after the first DONE, and `start` is ignored in LOAD, RUN and DONE.
- Reset asserted in RUN cycle 3 of a=0x12, B=0x34 → the next cycle shows IDLE, `p`=0, `busy`=0 and `done`=0. A fresh start of 0x12×0x34 then gives `p`=0x03A8.
- N=4, a=0xF, B=0xF → `p`=0xE1 with `done` at cycle 6. Then a=0x9, B=0x6 → `p`=0x36, and the previous `p` is held until that second DONE.

Source files
------------

// File: rtl/shift_add_mult_ctrl_if.sv
// rtl/shift_add_mult_ctrl_if.sv - start/busy/done handshake and operand/product bus
//
// Groups the request side of the shift-add multiplier controller.
//   start : request a multiplication (requester -> controller)
//   a     : N-bit multiplicand (requester -> controller)
//   p     : 2N-bit product (controller -> requester)
//   busy  : controller is in LOAD, RUN or DONE
//   done  : one-cycle pulse in DONE
// modport master: the requester side; modport slave: the controller side.
interface shift_add_mult_ctrl_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [2*N-1:0]   p;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output a,
        input  p,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        output p,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - shift-add multiplier controller and product accumulator
//
// Drives a downstream right-shifting multiplier register (load and enable) and
// accumulates the shifted multiplicand whenever that register's LSB is set.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   sr_lsb    : bit 0 of the downstream shift register
//   sr_load   : load pin of the shift register (loads multiplier B)
//   sr_enable : shift-enable of the shift register, one right shift per cycle
//   bus       : start/a in, p/busy/done out (shift_add_mult_ctrl_if.slave)
module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sr_lsb,
    output logic                  sr_load,
    output logic                  sr_enable,
    shift_add_mult_ctrl_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  p_reg;
    logic            busy_reg;
    logic            done_reg;

    // Multiplicand aligned to the current bit weight of B.
    logic [2*N-1:0]  addend;
    logic [2*N-1:0]  acc_next;

    assign addend   = {{N{1'b0}}, a_reg} << cnt;
    // The largest product (2^N-1)^2 fits in 2N bits, so no carry-out exists.
    assign acc_next = sr_lsb ? (acc + addend) : acc;

    assign bus.p    = p_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

    // Outputs are registered alongside the state so each one is a pure
    // function of the state held in the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            p_reg     <= '0;
            sr_load   <= 1'b0;
            sr_enable <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.a;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= LOAD;
                        sr_load  <= 1'b1;
                        busy_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    sr_load   <= 1'b0;
                    sr_enable <= 1'b1;
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Product includes the final add made on this edge.
                        p_reg     <= acc_next;
                        state     <= DONE;
                        sr_enable <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    // start is not looked at here; a request must be seen in IDLE.
                    state    <= IDLE;
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    sr_load   <= 1'b0;
                    sr_enable <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - directed self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=8 instance with its downstream right-shift register.
    shift_add_mult_ctrl_if #(.N(8)) bus8 ();
    logic       sr_load8, sr_enable8;
    logic [7:0] b8 = '0;
    logic [7:0] q8 = '0;

    shift_add_mult_ctrl #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .sr_lsb    (q8[0]),
        .sr_load   (sr_load8),
        .sr_enable (sr_enable8),
        .bus       (bus8.slave)
    );

    always @(posedge clk or posedge sr_load8) begin
        if (sr_load8)
            q8 <= b8;
        else if (sr_enable8)
            q8 <= q8 >> 1;
    end

    // N=4 instance with its downstream right-shift register.
    shift_add_mult_ctrl_if #(.N(4)) bus4 ();
    logic       sr_load4, sr_enable4;
    logic [3:0] b4 = '0;
    logic [3:0] q4 = '0;

    shift_add_mult_ctrl #(.N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .sr_lsb    (q4[0]),
        .sr_load   (sr_load4),
        .sr_enable (sr_enable4),
        .bus       (bus4.slave)
    );

    always @(posedge clk or posedge sr_load4) begin
        if (sr_load4)
            q4 <= b4;
        else if (sr_enable4)
            q4 <= q4 >> 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One N=8 operation: start pulse, then observe until done (bounded).
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] pexp);
        int lat;
        int en_cnt;
        int overlap;
        int held_bad;
        logic [15:0] prev;
        prev       = bus8.p;
        bus8.a     = av;
        b8         = bv;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a     = ~av;
        chk({tag, "_load"}, {31'b0, sr_load8}, 32'd1);
        chk({tag, "_busy"}, {31'b0, bus8.busy}, 32'd1);
        lat = 1; en_cnt = 0; overlap = 0; held_bad = 0;
        while (!bus8.done && lat < 40) begin
            if (sr_enable8) en_cnt++;
            if (sr_enable8 && sr_load8) overlap++;
            if (bus8.p !== prev) held_bad++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd10);
        chk({tag, "_en_cycles"}, en_cnt, 32'd8);
        chk({tag, "_overlap"}, overlap, 32'd0);
        chk({tag, "_p_held"}, held_bad, 32'd0);
        chk({tag, "_p"}, {16'b0, bus8.p}, {16'b0, pexp});
        tick();
        chk({tag, "_done_low"}, {31'b0, bus8.done}, 32'd0);
        chk({tag, "_idle"}, {31'b0, bus8.busy}, 32'd0);
        chk({tag, "_p_after"}, {16'b0, bus8.p}, {16'b0, pexp});
    endtask

    task automatic run4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] pexp);
        int lat;
        int en_cnt;
        int held_bad;
        logic [7:0] prev;
        prev       = bus4.p;
        bus4.a     = av;
        b4         = bv;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        chk({tag, "_load"}, {31'b0, sr_load4}, 32'd1);
        lat = 1; en_cnt = 0; held_bad = 0;
        while (!bus4.done && lat < 40) begin
            if (sr_enable4) en_cnt++;
            if (bus4.p !== prev) held_bad++;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd6);
        chk({tag, "_en_cycles"}, en_cnt, 32'd4);
        chk({tag, "_p_held"}, held_bad, 32'd0);
        chk({tag, "_p"}, {24'b0, bus4.p}, {24'b0, pexp});
        tick();
        chk({tag, "_idle"}, {31'b0, bus4.busy}, 32'd0);
    endtask

    initial begin
        int lat;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus4.start = 1'b0;
        bus4.a     = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'b0, bus8.busy}, 32'd0);
        chk("rst_done", {31'b0, bus8.done}, 32'd0);
        chk("rst_p", {16'b0, bus8.p}, 32'd0);
        chk("rst_load", {31'b0, sr_load8}, 32'd0);
        chk("rst_enable", {31'b0, sr_enable8}, 32'd0);
        chk("rst4_p", {24'b0, bus4.p}, 32'd0);
        tick();
        chk("idle_no_start", {31'b0, bus8.busy}, 32'd0);

        // Basic products
        run8("m0d0b", 8'h0D, 8'h0B, 16'h008F);
        tick();
        chk("held_idle", {16'b0, bus8.p}, 32'h008F);
        run8("mffff", 8'hFF, 8'hFF, 16'hFE01);
        run8("m00ab", 8'h00, 8'hAB, 16'h0000);
        run8("mab00", 8'hAB, 8'h00, 16'h0000);

        // start held high: one operation every N+3 cycles
        bus8.a     = 8'h03;
        b8         = 8'h05;
        bus8.start = 1'b1;
        tick();
        chk("hold_load1", {31'b0, sr_load8}, 32'd1);
        lat = 1;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("hold_latency", lat, 32'd10);
        chk("hold_p", {16'b0, bus8.p}, 32'h000F);
        tick();
        chk("hold_idle_after_done", {31'b0, bus8.busy}, 32'd0);
        chk("hold_no_reload_in_done", {31'b0, sr_load8}, 32'd0);
        tick();
        chk("hold_load2", {31'b0, sr_load8}, 32'd1);
        chk("hold_p_kept", {16'b0, bus8.p}, 32'h000F);
        bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("hold2_latency", lat, 32'd10);
        chk("hold2_p", {16'b0, bus8.p}, 32'h000F);
        tick();

        // Reset during RUN discards the partial result
        bus8.a     = 8'h12;
        b8         = 8'h34;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_run_enable", {31'b0, sr_enable8}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'b0, bus8.busy}, 32'd0);
        chk("mid_rst_done", {31'b0, bus8.done}, 32'd0);
        chk("mid_rst_p", {16'b0, bus8.p}, 32'd0);
        chk("mid_rst_enable", {31'b0, sr_enable8}, 32'd0);
        chk("mid_rst_load", {31'b0, sr_load8}, 32'd0);
        run8("m1234", 8'h12, 8'h34, 16'h03A8);

        // N=4 instance
        run4("n4_ff", 4'hF, 4'hF, 8'hE1);
        run4("n4_96", 4'h9, 4'h6, 8'h36);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
